// File: rtl/sa_result_drain_pkg.sv
// Shared definitions for the systolic-array result drain.
//   - drain_state_e : one-hot FSM encoding, matching the matrix manager
//   - sa_ri_w       : row-index width helper (never narrower than 1 bit)
//   - sa_elem_lsb   : LSB of element (r,c) inside a flattened row-major matrix
package sa_result_drain_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b01,
    S_DRAIN = 2'b10
  } drain_state_e;

  function automatic int sa_ri_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int sa_elem_lsb(input int r, input int c, input int w_c, input int d_w);
    return ((r * w_c) + c) * d_w;
  endfunction

endpackage

// File: rtl/sa_row_buffer.sv
// Holding buffer for one X_R x W_C result matrix.
// Ports:
//   I_CLK, I_ASYN_RSTN, I_SYNC_RSTN : clock, async/sync active-low resets (clear buffer)
//   capture_en : load the whole matrix_in on this edge
//   matrix_in  : flattened matrix, element (r,c) at [((r*W_C)+c)*D_W +: D_W]
//   rd_row     : row to present on row_out
//   row_out    : selected row, column c at [c*D_W +: D_W]
module sa_row_buffer
  import sa_result_drain_pkg::*;
#(
  parameter int D_W  = 16,
  parameter int X_R  = 16,
  parameter int W_C  = 16,
  parameter int RI_W = sa_ri_w(X_R)
) (
  input  logic                   I_CLK,
  input  logic                   I_ASYN_RSTN,
  input  logic                   I_SYNC_RSTN,
  input  logic                   capture_en,
  input  logic [X_R*W_C*D_W-1:0] matrix_in,
  input  logic [RI_W-1:0]        rd_row,
  output logic [W_C*D_W-1:0]     row_out
);

  logic [W_C*D_W-1:0] mem_p0 [X_R];

  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      for (int r = 0; r < X_R; r++) mem_p0[r] <= '0;
    end else if (!I_SYNC_RSTN) begin
      for (int r = 0; r < X_R; r++) mem_p0[r] <= '0;
    end else if (capture_en) begin
      for (int r = 0; r < X_R; r++)
        mem_p0[r] <= matrix_in[sa_elem_lsb(r, 0, W_C, D_W) +: W_C*D_W];
    end
  end

  // Compare-based mux keeps the index width independent of X_R being a power of 2.
  always_comb begin
    row_out = '0;
    for (int r = 0; r < X_R; r++)
      if (rd_row == RI_W'(r)) row_out = mem_p0[r];
  end

endmodule

// File: rtl/sa_result_drain.sv
// Snapshots the systolic-array result matrix on I_SA_OVER and streams it out
// one row per valid/ready transfer, so the array can restart independently
// of the consumer's speed.
// Ports:
//   I_CLK, I_ASYN_RSTN, I_SYNC_RSTN : clock, async/sync active-low resets
//   I_SA_OVER       : one-cycle pulse, I_RESULT_MATRIX valid
//   I_RESULT_MATRIX : flattened X_R x W_C matrix of D_W elements
//   I_READY         : consumer accepts the presented row
//   O_VALID         : O_ROW_VECTOR / O_ROW_IDX valid
//   O_ROW_IDX       : index of the presented row
//   O_ROW_VECTOR    : presented row (zero when not valid)
//   O_BUSY          : draining
//   O_DONE          : one-cycle pulse after the last row is accepted
//   O_OVERRUN       : sticky, a capture request arrived mid-drain and was dropped
module sa_result_drain
  import sa_result_drain_pkg::*;
#(
  parameter int D_W  = 16,
  parameter int X_R  = 16,
  parameter int W_C  = 16,
  parameter int RI_W = sa_ri_w(X_R)
) (
  input  logic                   I_CLK,
  input  logic                   I_ASYN_RSTN,
  input  logic                   I_SYNC_RSTN,
  input  logic                   I_SA_OVER,
  input  logic [X_R*W_C*D_W-1:0] I_RESULT_MATRIX,
  input  logic                   I_READY,
  output logic                   O_VALID,
  output logic [RI_W-1:0]        O_ROW_IDX,
  output logic [W_C*D_W-1:0]     O_ROW_VECTOR,
  output logic                   O_BUSY,
  output logic                   O_DONE,
  output logic                   O_OVERRUN
);

  drain_state_e       state_p0, state_nxt;
  logic [RI_W-1:0]    row_p0, row_nxt;
  logic               done_p0, done_nxt;
  logic               overrun_p0, overrun_nxt;
  logic               capture;
  logic               xfer;
  logic               last_row;
  logic [W_C*D_W-1:0] buf_row;

  assign O_VALID  = (state_p0 == S_DRAIN);
  assign xfer     = O_VALID & I_READY;
  assign last_row = (row_p0 == RI_W'(X_R - 1));

  always_comb begin
    state_nxt   = state_p0;
    row_nxt     = row_p0;
    done_nxt    = 1'b0;
    overrun_nxt = overrun_p0;
    capture     = 1'b0;
    case (state_p0)
      S_IDLE: begin
        if (I_SA_OVER) begin
          capture   = 1'b1;
          row_nxt   = '0;
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (xfer && last_row) begin
          done_nxt = 1'b1;
          row_nxt  = '0;
          // A new matrix landing on the final transfer chains straight into
          // the next drain with no bubble.
          if (I_SA_OVER) capture = 1'b1;
          else           state_nxt = S_IDLE;
        end else begin
          if (xfer) row_nxt = row_p0 + RI_W'(1);
          if (I_SA_OVER) overrun_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        row_nxt   = '0;
      end
    endcase
  end

  // Stage p0: control registers
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      state_p0   <= S_IDLE;
      row_p0     <= '0;
      done_p0    <= 1'b0;
      overrun_p0 <= 1'b0;
    end else if (!I_SYNC_RSTN) begin
      state_p0   <= S_IDLE;
      row_p0     <= '0;
      done_p0    <= 1'b0;
      overrun_p0 <= 1'b0;
    end else begin
      state_p0   <= state_nxt;
      row_p0     <= row_nxt;
      done_p0    <= done_nxt;
      overrun_p0 <= overrun_nxt;
    end
  end

  sa_row_buffer #(
    .D_W (D_W),
    .X_R (X_R),
    .W_C (W_C),
    .RI_W(RI_W)
  ) u_buf (
    .I_CLK      (I_CLK),
    .I_ASYN_RSTN(I_ASYN_RSTN),
    .I_SYNC_RSTN(I_SYNC_RSTN),
    .capture_en (capture),
    .matrix_in  (I_RESULT_MATRIX),
    .rd_row     (row_p0),
    .row_out    (buf_row)
  );

  assign O_ROW_IDX    = row_p0;
  assign O_ROW_VECTOR = O_VALID ? buf_row : '0;
  assign O_BUSY       = O_VALID;
  assign O_DONE       = done_p0;
  assign O_OVERRUN    = overrun_p0;

endmodule

// File: tb/tb_sa_result_drain.sv
module tb_sa_result_drain;

  localparam int D_W = 16;
  localparam int X_R = 4;
  localparam int W_C = 4;
  localparam int RI_W = 2;

  logic                   clk;
  logic                   asyn_rstn;
  logic                   sync_rstn;
  logic                   sa_over;
  logic [X_R*W_C*D_W-1:0] matrix;
  logic                   ready;
  logic                   valid;
  logic [RI_W-1:0]        row_idx;
  logic [W_C*D_W-1:0]     row_vec;
  logic                   busy;
  logic                   done;
  logic                   overrun;

  int errs;
  int checks;

  sa_result_drain #(.D_W(D_W), .X_R(X_R), .W_C(W_C), .RI_W(RI_W)) dut (
    .I_CLK          (clk),
    .I_ASYN_RSTN    (asyn_rstn),
    .I_SYNC_RSTN    (sync_rstn),
    .I_SA_OVER      (sa_over),
    .I_RESULT_MATRIX(matrix),
    .I_READY        (ready),
    .O_VALID        (valid),
    .O_ROW_IDX      (row_idx),
    .O_ROW_VECTOR   (row_vec),
    .O_BUSY         (busy),
    .O_DONE         (done),
    .O_OVERRUN      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind 0: 16*r+c, kind 1: all 0xFFFF, kind 2: 0x100+16*r+c
  function automatic logic [15:0] elem(input int kind, input int r, input int c);
    case (kind)
      0:       return 16'(16 * r + c);
      1:       return 16'hFFFF;
      default: return 16'(256 + 16 * r + c);
    endcase
  endfunction

  function automatic logic [X_R*W_C*D_W-1:0] mk_mat(input int kind);
    logic [X_R*W_C*D_W-1:0] m;
    m = '0;
    for (int r = 0; r < X_R; r++)
      for (int c = 0; c < W_C; c++)
        m[((r * W_C) + c) * D_W +: D_W] = elem(kind, r, c);
    return m;
  endfunction

  function automatic logic [63:0] exp_row(input int kind, input int r);
    return {elem(kind, r, 3), elem(kind, r, 2), elem(kind, r, 1), elem(kind, r, 0)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_row(input string tag, input int kind, input int r);
    check({tag, "_valid"}, 64'(valid), 64'd1);
    check({tag, "_idx"}, 64'(row_idx), 64'(r));
    check({tag, "_vec"}, row_vec, exp_row(kind, r));
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    errs = 0;
    checks = 0;
    asyn_rstn = 1'b0;
    sync_rstn = 1'b1;
    sa_over = 1'b0;
    ready = 1'b0;
    matrix = '0;
    tick();
    tick();
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_idx", 64'(row_idx), 64'd0);
    check("rst_vec", row_vec, 64'd0);
    asyn_rstn = 1'b1;
    tick();

    // Basic drain
    matrix = mk_mat(0); sa_over = 1'b1; ready = 1'b1;
    tick(); sa_over = 1'b0;
    check_row("basic_r0", 0, 0);
    check("basic_busy", 64'(busy), 64'd1);
    tick(); check_row("basic_r1", 0, 1);
    tick(); check_row("basic_r2", 0, 2);
    check("basic_r2_lit", row_vec, 64'h0023_0022_0021_0020);
    tick(); check_row("basic_r3", 0, 3);
    tick();
    check("basic_done", 64'(done), 64'd1);
    check("basic_valid_off", 64'(valid), 64'd0);
    check("basic_busy_off", 64'(busy), 64'd0);
    check("basic_vec_zero", row_vec, 64'd0);
    tick();
    check("basic_done_off", 64'(done), 64'd0);

    // Backpressure on row 1
    sa_over = 1'b1;
    tick(); sa_over = 1'b0;
    check_row("bp_r0", 0, 0);
    tick(); check_row("bp_r1a", 0, 1);
    ready = 1'b0;
    tick(); check_row("bp_r1b", 0, 1);
    tick(); check_row("bp_r1c", 0, 1);
    tick(); check_row("bp_r1d", 0, 1);
    ready = 1'b1;
    tick(); check_row("bp_r2", 0, 2);
    tick(); check_row("bp_r3", 0, 3);
    tick();
    check("bp_done", 64'(done), 64'd1);
    check("bp_valid_off", 64'(valid), 64'd0);
    tick();
    check("bp_done_once", 64'(done), 64'd0);

    // Overrun: capture request at row 1 is dropped
    sa_over = 1'b1;
    tick(); sa_over = 1'b0;
    check_row("ov_r0", 0, 0);
    tick(); check_row("ov_r1", 0, 1);
    matrix = mk_mat(1); sa_over = 1'b1;
    tick(); sa_over = 1'b0;
    check_row("ov_r2", 0, 2);
    check("ov_flag", 64'(overrun), 64'd1);
    tick(); check_row("ov_r3", 0, 3);
    tick();
    check("ov_done", 64'(done), 64'd1);
    check("ov_sticky", 64'(overrun), 64'd1);
    matrix = mk_mat(2); sa_over = 1'b1;
    tick(); sa_over = 1'b0;
    check_row("ov_next_r0", 2, 0);
    tick(); check_row("ov_next_r1", 2, 1);
    tick(); check_row("ov_next_r2", 2, 2);
    tick(); check_row("ov_next_r3", 2, 3);
    tick();
    check("ov_next_done", 64'(done), 64'd1);
    check("ov_still_set", 64'(overrun), 64'd1);
    sync_rstn = 1'b0;
    tick(); sync_rstn = 1'b1;
    check("ov_cleared", 64'(overrun), 64'd0);

    // Back-to-back: new capture on the final transfer
    matrix = mk_mat(0); sa_over = 1'b1;
    tick(); sa_over = 1'b0;
    check_row("b2b_r0", 0, 0);
    tick(); tick(); tick();
    check_row("b2b_r3", 0, 3);
    matrix = mk_mat(2); sa_over = 1'b1;
    tick(); sa_over = 1'b0;
    check("b2b_valid", 64'(valid), 64'd1);
    check("b2b_idx", 64'(row_idx), 64'd0);
    check("b2b_vec", row_vec, exp_row(2, 0));
    check("b2b_done", 64'(done), 64'd1);
    check("b2b_no_overrun", 64'(overrun), 64'd0);
    tick(); check_row("b2b_n1", 2, 1);
    tick(); check_row("b2b_n2", 2, 2);
    tick(); check_row("b2b_n3", 2, 3);
    tick();
    check("b2b_done2", 64'(done), 64'd1);
    check("b2b_idle", 64'(valid), 64'd0);

    // Sync reset mid-drain
    matrix = mk_mat(0); sa_over = 1'b1;
    tick(); sa_over = 1'b0;
    tick(); tick();
    check_row("srst_r2", 0, 2);
    sync_rstn = 1'b0;
    tick(); sync_rstn = 1'b1;
    check("srst_valid", 64'(valid), 64'd0);
    check("srst_busy", 64'(busy), 64'd0);
    check("srst_vec", row_vec, 64'd0);
    check("srst_done", 64'(done), 64'd0);
    tick();
    check("srst_no_done", 64'(done), 64'd0);
    check("srst_stay_idle", 64'(valid), 64'd0);

    // Async reset mid-cycle
    sa_over = 1'b1;
    tick(); sa_over = 1'b0;
    tick(); tick();
    check_row("arst_r2", 0, 2);
    #2 asyn_rstn = 1'b0;
    #1;
    check("arst_valid", 64'(valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_vec", row_vec, 64'd0);
    check("arst_idx", 64'(row_idx), 64'd0);
    asyn_rstn = 1'b1;
    tick();
    check("arst_no_done", 64'(done), 64'd0);

    // Idle guard: ready toggles, no capture request
    for (int i = 0; i < 6; i++) begin
      ready = i[0];
      tick();
      check("idle_valid", 64'(valid), 64'd0);
      check("idle_done", 64'(done), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/sa_result_drain.md
Name: sa_result_drain

Overview:
- Sits directly downstream of the systolic array that the SA matrix manager feeds.
- When the array signals its accumulation is complete, the block snapshots the full X_R x W_C result matrix into a holding buffer.
- It then streams the buffer out one row per transfer to the next MHA stage (scaling/softmax) using a valid/ready handshake.
- This decouples array restart from the speed of the consumer.

Parameters:
- D_W, 16, bit width of one result element.
- X_R, 16, number of result rows (matches the X matrix rows fed to the array).
- W_C, 16, number of result columns (matches the W matrix columns fed to the array).
- RI_W, $clog2(X_R) (minimum 1), width of the row index output.

Ports:
- I_CLK  in  1  clock.
- I_ASYN_RSTN  in  1  reset, asynchronous, active-low.
- I_SYNC_RSTN  in  1  synchronous reset, active-low; same effect as async reset, applied at the clock edge.
- I_SA_OVER  in  1  single-cycle pulse; I_RESULT_MATRIX is valid this cycle.
- I_RESULT_MATRIX  in  X_R*W_C*D_W  result matrix; element (r,c) at bits [((r*W_C)+c)*D_W +: D_W].
- I_READY  in  1  consumer accepts O_ROW_VECTOR this cycle.
- O_VALID  out  1  O_ROW_VECTOR and O_ROW_IDX are valid.
- O_ROW_IDX  out  RI_W  index of the row currently presented.
- O_ROW_VECTOR  out  W_C*D_W  row O_ROW_IDX; column c at bits [c*D_W +: D_W].
- O_BUSY  out  1  high while in S_DRAIN.
- O_DONE  out  1  one-cycle pulse after the last row is accepted.
- O_OVERRUN  out  1  sticky; set when a capture request is dropped.

Behaviour:
- Reset (async or sync): state=S_IDLE, row=0, buffer cleared to 0. Outputs: O_VALID=0, O_BUSY=0, O_DONE=0, O_OVERRUN=0, O_ROW_IDX=0, O_ROW_VECTOR=0.
- Reset mid-drain aborts the drain immediately. No O_DONE is generated and remaining rows are discarded.
- Handshake: a transfer occurs on a rising edge where O_VALID & I_READY.
  - While O_VALID=1 and I_READY=0, O_ROW_VECTOR and O_ROW_IDX must hold stable.
  - O_VALID never drops without a transfer, except on reset.
- Output path: O_ROW_VECTOR is a combinational mux of buffer[row] when O_VALID=1; it is all-zero when O_VALID=0.
- S_IDLE:
  - If I_SA_OVER: register I_RESULT_MATRIX into the buffer, set row=0, go to S_DRAIN.
  - O_VALID rises the cycle after the I_SA_OVER edge (capture latency 1).
- S_DRAIN: O_VALID=1, O_BUSY=1.
  - Transfer with row<X_R-1: row increments.
  - Transfer with row==X_R-1: go to S_IDLE, row=0, O_DONE=1 for the next cycle only.
- I_SA_OVER while in S_DRAIN, not on the final transfer: capture is dropped, buffer is unchanged, O_OVERRUN is set. O_OVERRUN clears only on reset.
- Simultaneous final transfer and I_SA_OVER: the new matrix is captured, row=0, state stays S_DRAIN, O_VALID stays 1 with no bubble. O_DONE still pulses for the completed matrix; no overrun.
- Throughput: with I_READY held high, a full matrix drains in exactly X_R cycles. Back-to-back matrices are possible with zero idle cycles.
- X_R=1: the first transfer is the final transfer.
- Data is passed through unmodified; no arithmetic, saturation or sign handling.

Decomposition:
- Shared package/defines:
  - state encodings S_IDLE=2'b01, S_DRAIN=2'b10 (one-hot, in line with the manager);
  - the matrix flatten/unflatten macro reused from the existing defines;
  - the row-index width helper.
- One natural sub-module: sa_row_buffer.
  - Contents: X_R x W_C x D_W register array with a capture-enable write port and a row read mux.
  - The FSM, counter and flags stay in sa_result_drain.

Test Plan:
- Basic drain: X_R=4, W_C=4, D_W=16, element (r,c)=16*r+c, one I_SA_OVER pulse, I_READY=1 -> O_VALID high for 4 consecutive cycles with O_ROW_IDX 0,1,2,3; row 2 = {0x23,0x22,0x21,0x20}; O_DONE pulse in the cycle after row 3; O_BUSY low afterwards.
- Backpressure: same matrix, I_READY low for 3 cycles while row 1 is presented -> row 1 data and O_ROW_IDX=1 held stable for 4 cycles; total drain 7 cycles; O_DONE once.
- Overrun: second I_SA_OVER with all elements =0xFFFF at row 1 -> O_OVERRUN=1 and stays 1; rows 2,3 still carry original data; subsequent drain unaffected.
- Back-to-back: second I_SA_OVER coincident with the row-3 transfer -> next cycle O_VALID=1, O_ROW_IDX=0 with new data, O_DONE=1 in that same cycle, O_OVERRUN=0.
- Reset mid-drain: assert I_SYNC_RSTN=0 at row 2 -> next cycle O_VALID=0, O_BUSY=0, O_ROW_VECTOR=0, no O_DONE; repeat with I_ASYN_RSTN mid-cycle -> outputs clear immediately.
- Idle guard: I_READY toggling with no I_SA_OVER -> O_VALID stays 0, no O_DONE, buffer unchanged.
